// File: rtl/pixel_readout_buffer.sv
// rtl/pixel_readout_buffer.sv - row capture, row FIFO and tagged pixel stream serialiser
module pixel_readout_buffer #(
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int PIXEL_BITS         = 8,
    parameter int FIFO_DEPTH         = 2,
    parameter int CAPTURE_DELAY      = 1
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic                                    NEW_ROW,
    input  logic                                    FRAME_FINISHED,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] ROW_DATA,
    output logic [PIXEL_BITS-1:0]                   OUT_DATA,
    output logic                                    OUT_VALID,
    input  logic                                    OUT_READY,
    output logic                                    OUT_SOF,
    output logic                                    OUT_EOL,
    output logic                                    OUT_EOF,
    output logic                                    OVERFLOW
);

    localparam int ROW_W = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int CW    = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;
    localparam int RW    = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW  = $clog2(FIFO_DEPTH + 1);
    localparam int TW    = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;

    localparam logic [CW-1:0]   COL_LAST   = CW'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [AW-1:0]   IDX_LAST   = AW'(FIFO_DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_FULL   = CNTW'(FIFO_DEPTH);
    localparam logic [TW-1:0]   TIMER_INIT = TW'((CAPTURE_DELAY > 0) ? CAPTURE_DELAY - 1 : 0);

    typedef enum logic {
        CAP_IDLE,
        CAP_WAIT
    } cap_state_t;

    cap_state_t       cap_state;
    cap_state_t       cap_next;
    logic [TW-1:0]    timer;
    logic             timer_load;
    logic             push;
    logic [RW-1:0]    row_pos;
    logic [RW-1:0]    push_row;
    logic [RW-1:0]    row_pos_inc;

    logic [ROW_W-1:0] mem_data [FIFO_DEPTH];
    logic [RW-1:0]    mem_row  [FIFO_DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    rd_idx_nxt;
    logic [AW-1:0]    wr_idx_nxt;
    logic [CNTW-1:0]  count;
    logic             full;
    logic             pop;
    logic             push_acc;

    logic [CW-1:0]    col;
    logic [CW-1:0]    col_nxt;
    logic [RW-1:0]    out_row;
    logic [ROW_W-1:0] head_data;
    logic [ROW_W-1:0] next_data;

    // Capture FSM: a restart or frame resync in WAIT abandons the row being settled.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cap_state <= CAP_IDLE;
        end else begin
            cap_state <= cap_next;
        end
    end

    always_comb begin
        cap_next   = cap_state;
        timer_load = 1'b0;
        push       = 1'b0;
        if (CAPTURE_DELAY == 0) begin
            push = NEW_ROW;
        end else begin
            case (cap_state)
                CAP_IDLE: begin
                    if (NEW_ROW) begin
                        cap_next   = CAP_WAIT;
                        timer_load = 1'b1;
                    end
                end
                CAP_WAIT: begin
                    if (NEW_ROW) begin
                        timer_load = 1'b1;
                    end else if (FRAME_FINISHED) begin
                        cap_next = CAP_IDLE;
                    end else if (timer == '0) begin
                        push     = 1'b1;
                        cap_next = CAP_IDLE;
                    end
                end
                default: cap_next = CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            timer <= '0;
        end else if (timer_load) begin
            timer <= TIMER_INIT;
        end else if (cap_state == CAP_WAIT && timer != '0) begin
            timer <= timer - TW'(1);
        end
    end

    // A same-edge resync (only possible with zero delay) tags the sampled row as row 0.
    assign push_row    = FRAME_FINISHED ? '0 : row_pos;
    assign row_pos_inc = (push_row == ROW_LAST) ? '0 : push_row + RW'(1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            row_pos <= '0;
        end else if (FRAME_FINISHED) begin
            row_pos <= push ? row_pos_inc : '0;
        end else if (push) begin
            row_pos <= row_pos_inc;
        end
    end

    assign full       = (count == CNT_FULL);
    assign pop        = OUT_VALID && OUT_READY && (col == COL_LAST);
    assign push_acc   = push && (!full || pop);
    assign rd_idx_nxt = (rd_idx == IDX_LAST) ? '0 : rd_idx + AW'(1);
    assign wr_idx_nxt = (wr_idx == IDX_LAST) ? '0 : wr_idx + AW'(1);

    always_ff @(posedge CLK) begin
        if (push_acc) begin
            mem_data[wr_idx] <= ROW_DATA;
            mem_row[wr_idx]  <= push_row;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_idx <= wr_idx_nxt;
            end
            if (pop) begin
                rd_idx <= rd_idx_nxt;
            end
            case ({push_acc, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    assign head_data = mem_data[rd_idx];
    assign next_data = mem_data[rd_idx_nxt];
    assign col_nxt   = col + CW'(1);

    // The head row stays in the FIFO until its last pixel transfers; the next row follows without a gap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            col       <= '0;
            out_row   <= '0;
        end else if (!OUT_VALID) begin
            if (count != '0) begin
                OUT_VALID <= 1'b1;
                OUT_DATA  <= head_data[PIXEL_BITS-1:0];
                out_row   <= mem_row[rd_idx];
                col       <= '0;
            end
        end else if (OUT_READY) begin
            if (col != COL_LAST) begin
                col      <= col_nxt;
                OUT_DATA <= head_data[int'(col_nxt)*PIXEL_BITS +: PIXEL_BITS];
            end else if (count > CNTW'(1)) begin
                col      <= '0;
                OUT_DATA <= next_data[PIXEL_BITS-1:0];
                out_row  <= mem_row[rd_idx_nxt];
            end else begin
                OUT_VALID <= 1'b0;
                col       <= '0;
            end
        end
    end

    assign OUT_SOF = OUT_VALID && (out_row == '0) && (col == '0);
    assign OUT_EOL = OUT_VALID && (col == COL_LAST);
    assign OUT_EOF = OUT_VALID && (out_row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// tb/tb_pixel_readout_buffer.sv - directed vector bench for pixel_readout_buffer
module tb_pixel_readout_buffer;

    logic        CLK;
    logic        RESET;
    logic        NEW_ROW;
    logic        FRAME_FINISHED;
    logic [15:0] ROW_DATA;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_SOF;
    logic        OUT_EOL;
    logic        OUT_EOF;
    logic        OVERFLOW;

    int checks = 0;
    int errors = 0;

    pixel_readout_buffer #(
        .PIXEL_ARRAY_WIDTH (2),
        .PIXEL_ARRAY_HEIGHT(2),
        .PIXEL_BITS        (8),
        .FIFO_DEPTH        (2),
        .CAPTURE_DELAY     (1)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .NEW_ROW       (NEW_ROW),
        .FRAME_FINISHED(FRAME_FINISHED),
        .ROW_DATA      (ROW_DATA),
        .OUT_DATA      (OUT_DATA),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .OUT_SOF       (OUT_SOF),
        .OUT_EOL       (OUT_EOL),
        .OUT_EOF       (OUT_EOF),
        .OVERFLOW      (OVERFLOW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Observation word {valid, sof, eol, eof, overflow, data}; data only matters while valid.
    typedef struct {
        logic        nr;
        logic        ff;
        logic [15:0] rd;
        logic        rdy;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [12:0] e(input logic v, input logic s, input logic l,
                                      input logic f, input logic o, input logic [7:0] d);
        return {v, s, l, f, o, d};
    endfunction

    function automatic vec_t mkv(input logic nr, input logic ff, input logic [15:0] rd,
                                 input logic rdy, input logic [12:0] exp);
        vec_t t;
        t.nr  = nr;
        t.ff  = ff;
        t.rd  = rd;
        t.rdy = rdy;
        t.exp = exp;
        return t;
    endfunction

    function automatic logic [12:0] obs();
        return {OUT_VALID, OUT_SOF, OUT_EOL, OUT_EOF, OVERFLOW, OUT_VALID ? OUT_DATA : 8'h00};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET          = 1'b1;
        NEW_ROW        = 1'b0;
        FRAME_FINISHED = 1'b0;
        OUT_READY      = 1'b0;
        ROW_DATA       = 16'h0000;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic push_row(input logic [15:0] d);
        NEW_ROW  = 1'b1;
        ROW_DATA = d;
        tick();
        NEW_ROW  = 1'b0;
        tick();
    endtask

    initial begin
        RESET          = 1'b1;
        NEW_ROW        = 1'b0;
        FRAME_FINISHED = 1'b0;
        OUT_READY      = 1'b0;
        ROW_DATA       = 16'h0000;

        // Basic two-row frame, then resync mid-frame
        vecs[0]  = mkv(1, 0, 16'hBBAA, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[1]  = mkv(0, 0, 16'hBBAA, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[2]  = mkv(0, 0, 16'hBBAA, 1, e(1, 1, 0, 0, 0, 8'hAA));
        vecs[3]  = mkv(0, 0, 16'hBBAA, 1, e(1, 0, 1, 0, 0, 8'hBB));
        vecs[4]  = mkv(0, 0, 16'hBBAA, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[5]  = mkv(1, 0, 16'hDDCC, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[6]  = mkv(0, 0, 16'hDDCC, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[7]  = mkv(0, 0, 16'hDDCC, 1, e(1, 0, 0, 0, 0, 8'hCC));
        vecs[8]  = mkv(0, 0, 16'hDDCC, 1, e(1, 0, 1, 1, 0, 8'hDD));
        vecs[9]  = mkv(0, 0, 16'hDDCC, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[10] = mkv(1, 0, 16'h1211, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[11] = mkv(0, 0, 16'h1211, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[12] = mkv(0, 1, 16'h1211, 1, e(1, 1, 0, 0, 0, 8'h11));
        vecs[13] = mkv(1, 0, 16'h2221, 1, e(1, 0, 1, 0, 0, 8'h12));
        vecs[14] = mkv(0, 0, 16'h2221, 1, e(0, 0, 0, 0, 0, 8'h00));
        vecs[15] = mkv(0, 0, 16'h2221, 1, e(1, 1, 0, 0, 0, 8'h21));
        vecs[16] = mkv(0, 0, 16'h2221, 1, e(1, 0, 1, 0, 0, 8'h22));
        vecs[17] = mkv(0, 0, 16'h2221, 1, e(0, 0, 0, 0, 0, 8'h00));

        do_reset();
        check("reset_state", obs(), e(0, 0, 0, 0, 0, 8'h00));

        for (int i = 0; i < 18; i++) begin
            NEW_ROW        = vecs[i].nr;
            FRAME_FINISHED = vecs[i].ff;
            ROW_DATA       = vecs[i].rd;
            OUT_READY      = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end
        NEW_ROW        = 1'b0;
        FRAME_FINISHED = 1'b0;

        // Backpressure holds the head pixel and its tags
        do_reset();
        push_row(16'hBBAA);
        tick();
        check("bp_first", obs(), e(1, 1, 0, 0, 0, 8'hAA));
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), obs(), e(1, 1, 0, 0, 0, 8'hAA));
        end
        OUT_READY = 1'b1;
        tick();
        check("bp_bb", obs(), e(1, 0, 1, 0, 0, 8'hBB));
        tick();
        check("bp_done", obs(), e(0, 0, 0, 0, 0, 8'h00));

        // Overflow: third row dropped but still advances row position
        do_reset();
        push_row(16'h0201);
        push_row(16'h0403);
        push_row(16'h0605);
        check("ovf_set", obs(), e(1, 1, 0, 0, 1, 8'h01));
        OUT_READY = 1'b1;
        tick();
        check("ovf_02", obs(), e(1, 0, 1, 0, 1, 8'h02));
        tick();
        check("ovf_03", obs(), e(1, 0, 0, 0, 1, 8'h03));
        tick();
        check("ovf_04", obs(), e(1, 0, 1, 1, 1, 8'h04));
        tick();
        check("ovf_empty", obs(), e(0, 0, 0, 0, 1, 8'h00));
        push_row(16'h0807);
        tick();
        check("ovf_wrap_07", obs(), e(1, 0, 0, 0, 1, 8'h07));
        tick();
        check("ovf_wrap_08", obs(), e(1, 0, 1, 1, 1, 8'h08));

        // Asynchronous reset mid-row
        do_reset();
        push_row(16'hBBAA);
        tick();
        check("rst_aa", obs(), e(1, 1, 0, 0, 0, 8'hAA));
        OUT_READY = 1'b1;
        tick();
        check("rst_bb_shown", obs(), e(1, 0, 1, 0, 0, 8'hBB));
        #2;
        RESET = 1'b1;
        #1;
        check("rst_async", obs(), e(0, 0, 0, 0, 0, 8'h00));
        tick();
        RESET = 1'b0;
        tick();
        check("rst_quiet0", obs(), e(0, 0, 0, 0, 0, 8'h00));
        tick();
        check("rst_quiet1", obs(), e(0, 0, 0, 0, 0, 8'h00));
        push_row(16'h1211);
        tick();
        check("rst_next_sof", obs(), e(1, 1, 0, 0, 0, 8'h11));

        // Push coinciding with last-column pop while full
        do_reset();
        push_row(16'h0201);
        push_row(16'h0403);
        check("fp_full", obs(), e(1, 1, 0, 0, 0, 8'h01));
        NEW_ROW   = 1'b1;
        ROW_DATA  = 16'h0605;
        OUT_READY = 1'b1;
        tick();
        check("fp_02", obs(), e(1, 0, 1, 0, 0, 8'h02));
        NEW_ROW = 1'b0;
        tick();
        check("fp_03", obs(), e(1, 0, 0, 0, 0, 8'h03));
        tick();
        check("fp_04", obs(), e(1, 0, 1, 1, 0, 8'h04));
        tick();
        check("fp_05", obs(), e(1, 1, 0, 0, 0, 8'h05));
        tick();
        check("fp_06", obs(), e(1, 0, 1, 0, 0, 8'h06));
        tick();
        check("fp_empty", obs(), e(0, 0, 0, 0, 0, 8'h00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
